booth_seq_multiplier: RTL

- Multi-cycle signed radix-2 Booth multiplier; the ALU's multiply path.
- Accepts two N-bit two's-complement operands through a valid/ready handshake and iterates N add/shift steps through one bN_adder instance of width N+1.
- Produces a 2N-bit product, plus a flag that is set when the product does not fit the ALU's N-bit result word.
- Consumes the adder directly: it is the sequential stage built on top of the ripple-carry adder.

---
 rtl/booth_seq_multiplier_pkg.sv | 27 ++
 rtl/bN_adder.sv | 26 ++
 rtl/booth_seq_multiplier.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/booth_seq_multiplier_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM state encodings
// and the radix-2 Booth addend select codes.
package booth_seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NEG  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_M    = 2'd1,
    SEL_NM   = 2'd2
  } booth_sel_t;

  // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_m1}.
  function automatic booth_sel_t booth_select(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return SEL_M;
      2'b10:   return SEL_NM;
      default: return SEL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/bN_adder.sv
// N-bit ripple-carry adder with carry-in and signed-overflow flag.
module bN_adder #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         overflow
);

  logic [N:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign overflow = carry[N] ^ carry[N-1];

endmodule

// File: rtl/booth_seq_multiplier.sv
// Multi-cycle signed radix-2 Booth multiplier built on one shared bN_adder.
// Optional macro MUL_ZERO_BYPASS_EN: zero operands skip NEG/RUN and finish in one cycle.
module booth_seq_multiplier
  import booth_seq_multiplier_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           overflow
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          state_reg;
  logic [N:0]      m_reg;
  logic [N:0]      nm_reg;
  logic [N:0]      acc_reg;
  logic [N-1:0]    q_reg;
  logic            qm1_reg;
  logic [CW-1:0]   count_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic [2*N-1:0]  product_reg;
  logic            overflow_reg;

  logic [N:0]      add_a;
  logic [N:0]      add_b;
  logic            add_cin;
  logic [N:0]      add_sum;
  logic            add_ovf;

  logic [N:0]      acc_next;
  logic [N-1:0]    q_next;
  logic [2*N-1:0]  product_next;
  logic [N:0]      prod_hi;

  // One adder serves both phases: NEG forms ~M + 1, RUN forms ACC + Booth addend.
  always_comb begin
    add_a   = acc_reg;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_reg == NEG) begin
      add_a   = ~m_reg;
      add_cin = 1'b1;
    end else begin
      case (booth_select(q_reg[0], qm1_reg))
        SEL_M:   add_b = m_reg;
        SEL_NM:  add_b = nm_reg;
        default: add_b = '0;
      endcase
    end
  end

  bN_adder #(.N(N + 1)) u_adder (
    .a        (add_a),
    .b        (add_b),
    .cin      (add_cin),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  assign acc_next     = {add_sum[N], add_sum[N:1]};
  assign q_next       = {add_sum[0], q_reg[N-1:1]};
  assign product_next = {acc_next[N-1:0], q_next};
  assign prod_hi      = product_next[2*N-1:N-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      m_reg         <= '0;
      nm_reg        <= '0;
      acc_reg       <= '0;
      q_reg         <= '0;
      qm1_reg       <= 1'b0;
      count_reg     <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      product_reg   <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            in_ready_reg <= 1'b0;
            m_reg        <= {a[N-1], a};
            q_reg        <= b;
            qm1_reg      <= 1'b0;
            acc_reg      <= '0;
`ifdef MUL_ZERO_BYPASS_EN
            if (a == '0 || b == '0) begin
              state_reg     <= DONE;
              product_reg   <= '0;
              overflow_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
            end else begin
              state_reg <= NEG;
            end
`else
            state_reg <= NEG;
`endif
          end
        end
        NEG: begin
          nm_reg    <= add_sum;
          count_reg <= '0;
          state_reg <= RUN;
        end
        RUN: begin
          acc_reg   <= acc_next;
          q_reg     <= q_next;
          qm1_reg   <= q_reg[0];
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST) begin
            state_reg     <= DONE;
            product_reg   <= product_next;
            // Fits N signed bits only if the top N+1 product bits are a pure sign run.
            overflow_reg  <= !((&prod_hi) || (~|prod_hi));
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The N+1-bit datapath leaves headroom, so the adder can never overflow while in use.
  always_ff @(posedge clk) begin
    if (!rst && (state_reg == NEG || state_reg == RUN)) begin
      assert (!add_ovf);
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign product   = product_reg;
  assign overflow  = overflow_reg;

endmodule
